// File: rtl/sr_ff_bank.sv
// Bank of clocked set/reset flip-flops with per-channel enable, parallel load,
// selectable S=R=1 resolution and sticky conflict monitoring with a
// saturating conflict-cycle counter.
module sr_ff_bank #(
  parameter int unsigned     CHANNELS      = 4,
  parameter int unsigned     WIDTH         = 8,
  parameter int unsigned     CONFLICT_MODE = 0,  // 0 hold, 1 set, 2 reset, 3 toggle
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned     CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       EN,
  input  logic [CHANNELS-1:0]       LD,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS*WIDTH-1:0] S,
  input  logic [CHANNELS*WIDTH-1:0] R,
  input  logic                      flag_clr,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS*WIDTH-1:0] Q_bar,
  output logic [CHANNELS-1:0]       conflict,
  output logic [CNT_W-1:0]          conflict_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CHANNELS*WIDTH-1:0] q_q, q_d;
  logic [CHANNELS-1:0]       flag_q, flag_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]       conf_ev;
  logic                      any_ev;

  // Per-channel, per-bit next state with enable > load > set/reset priority.
  always_comb begin
    q_d     = q_q;
    conf_ev = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (EN[c]) begin
        if (LD[c]) begin
          q_d[c*WIDTH +: WIDTH] = D[c*WIDTH +: WIDTH];
        end else begin
          conf_ev[c] = |(S[c*WIDTH +: WIDTH] & R[c*WIDTH +: WIDTH]);
          for (int unsigned b = 0; b < WIDTH; b++) begin
            unique case ({S[c*WIDTH+b], R[c*WIDTH+b]})
              2'b10:   q_d[c*WIDTH+b] = 1'b1;
              2'b01:   q_d[c*WIDTH+b] = 1'b0;
              2'b11: begin
                case (CONFLICT_MODE)
                  1:       q_d[c*WIDTH+b] = 1'b1;
                  2:       q_d[c*WIDTH+b] = 1'b0;
                  3:       q_d[c*WIDTH+b] = ~q_q[c*WIDTH+b];
                  default: q_d[c*WIDTH+b] = q_q[c*WIDTH+b];
                endcase
              end
              default: q_d[c*WIDTH+b] = q_q[c*WIDTH+b];
            endcase
          end
        end
      end
    end
  end

  // Sticky flags and saturating counter; a same-edge conflict overrides the clear.
  always_comb begin
    any_ev = |conf_ev;
    flag_d = flag_clr ? conf_ev : (flag_q | conf_ev);
    cnt_d  = cnt_q;
    if (flag_clr) begin
      cnt_d = any_ev ? CNT_W'(1) : '0;
    end else if (any_ev && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= {CHANNELS{RESET_VALUE}};
      flag_q <= '0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q            = q_q;
  assign Q_bar        = ~q_q;
  assign conflict     = flag_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised, clocked bank of set/reset flip-flops: CHANNELS independent channels of WIDTH bits each, with per-channel enable, parallel load, configurable resolution of the S=R=1 condition, and conflict monitoring. It generalises the single asynchronous SR latch, gated SR latch and single-bit D flip-flop into one synchronous storage block. It is the team's standard status/control register primitive for FPGA designs. All storage is edge-triggered; there are no latches.

## Interface
- CHANNELS, 4: number of independent channels (≥1)
- WIDTH, 8: bits per channel (≥1)
- CONFLICT_MODE, 0: S=R=1 resolution; 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
- RESET_VALUE, 0: WIDTH-bit value loaded into every channel on reset
- CNT_W, 8: width of conflict_cnt (≥2)

- clk  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-high; all state to reset values immediately
- EN  in  CHANNELS  per-channel enable; bit c gates channel c
- LD  in  CHANNELS  per-channel parallel load; bit c loads channel c
- D  in  CHANNELS*WIDTH  load data; channel c is D[c*WIDTH +: WIDTH]
- S  in  CHANNELS*WIDTH  per-bit set request, same slicing
- R  in  CHANNELS*WIDTH  per-bit reset request, same slicing
- flag_clr  in  1  synchronous clear of conflict flags and counter
- Q  out  CHANNELS*WIDTH  registered state
- Q_bar  out  CHANNELS*WIDTH  always exactly ~Q (combinational from Q)
- conflict  out  CHANNELS  sticky per-channel conflict flag
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

## Operation
- Reset: Q = RESET_VALUE in every channel, Q_bar = ~RESET_VALUE, conflict = 0, conflict_cnt = 0.
- Per channel c, per clock edge, priority high to low:
  - EN[c]=0: hold all bits; S, R, LD, D ignored; no conflict recorded.
  - EN[c]=1, LD[c]=1: Q slice <= D slice; S/R ignored; no conflict recorded.
  - EN[c]=1, LD[c]=0, per bit: S=1,R=0 -> 1; S=0,R=1 -> 0; S=0,R=0 -> hold; S=1,R=1 -> per CONFLICT_MODE (hold / 1 / 0 / invert).
- Conflict event, channel c: EN[c]=1, LD[c]=0, and any bit of that slice has S&R=1. Recorded in every mode, including those that resolve it.
- conflict[c]: set on a conflict event in c; stays set until flag_clr.
- conflict_cnt: +1 on each edge where at least one channel has a conflict event. One count per cycle regardless of how many channels or bits conflict. Saturates at 2^CNT_W-1 with no wrap.
- flag_clr=1 at an edge: all flags to 0 and counter to 0, unless a conflict event occurs at the same edge. In that case the conflicting channels' flags are 1, others 0, and conflict_cnt = 1 (new event wins over clear).
- Q_bar is never equal to Q. The latch's invalid Q=Q_bar state cannot occur.

## Timing
- Inputs are sampled at the rising clk edge. Q, Q_bar, conflict and conflict_cnt reflect the edge one cycle later, i.e. latency 1.
- No combinational path from any input to any output. Q_bar depends only on Q.
- reset assertion clears state without a clock edge. Deassertion is synchronised externally. The first edge with reset=0 performs normal operation.
- Reset asserted mid-toggle or mid-load discards the pending update.
- Channels are fully independent. Simultaneous operations on different channels all take effect at the same edge.

## Test plan
- Reset and hold: reset=1 with RESET_VALUE=8'hA5 -> all Q slices 8'hA5, Q_bar 8'h5A, conflict 0, cnt 0. Then reset=0 with EN=0 and random S/R for 10 cycles -> Q unchanged.
- Set/reset per bit: channel 1, EN=1, S=8'h0F, R=8'h00, then S=0, R=8'h03 -> Q[1] goes 8'h00 -> 8'h0F -> 8'h0C on successive edges. Other channels are unchanged.
- Conflict modes: Q=8'h0F, then S=R=8'hFF for one edge, run once per CONFLICT_MODE 0/1/2/3 -> 8'h0F / 8'hFF / 8'h00 / 8'hF0. In every mode conflict[c]=1 and cnt=1.
- Load priority and gating: EN=1, LD=1, D=8'h3C with S=R=8'hFF -> Q=8'h3C, no conflict. The same stimulus with EN=0 -> Q holds, no conflict.
- Counter: CNT_W=2, conflicts in channels 0 and 2 on the same edge -> cnt=1. Five further conflict cycles -> cnt saturates at 3.
- Clear vs event: flag_clr=1 alone -> flags 0, cnt 0. flag_clr=1 coinciding with a channel-3 conflict -> conflict=4'b1000, cnt=1. Assert reset mid-sequence -> immediate return to reset values.
